// File: rtl/intr_pkg.sv
// Shared definitions for the pipelined-CPU interrupt controller:
// FSM state encoding and config register addresses.
package intr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_EOI  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int STAT_INTR_BIT = 7;
    localparam int STAT_SERV_BIT = 8;

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set request index wins.
module intr_prio_enc #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
) (
    input  logic [NIRQ-1:0] req,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a latch.
        valid = |req;
        id    = '0;
        // Scanning downward lets the lowest set index overwrite any higher one.
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/pipe_intr_controller.sv
// Edge-latching, masked, fixed-priority interrupt controller with a single
// in-service slot released by an EOI write on the config port.
module pipe_intr_controller
    import intr_pkg::*;
#(
    parameter int NIRQ = 8,
    parameter int IDW  = $clog2(NIRQ)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NIRQ-1:0] irq,
    input  logic            inta,
    output logic            intr,
    output logic [IDW-1:0]  intr_id,
    output logic            in_service,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata
);

    state_e          state_q, state_d;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic            intr_q, intr_d;
    logic [IDW-1:0]  intr_id_q, intr_id_d;
    logic            in_service_q, in_service_d;

    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pend_clr;
    logic            elig_valid;
    logic [IDW-1:0]  elig_id;
    logic            mask_we, pend_we, eoi_we;
    logic            unused_wdata;

    assign eligible     = pending_q & mask_q;
    assign unused_wdata = ^cfg_wdata;

    intr_prio_enc #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (elig_valid),
        .id    (elig_id)
    );

    always_comb begin
        mask_we   = cfg_we && (cfg_addr == ADDR_MASK);
        pend_we   = cfg_we && (cfg_addr == ADDR_PEND);
        eoi_we    = cfg_we && (cfg_addr == ADDR_EOI);
        rise      = irq & ~irq_q;
        state_d   = state_q;
        intr_id_d = intr_id_q;
        pend_clr  = pend_we ? cfg_wdata[NIRQ-1:0] : '0;
        mask_d    = mask_we ? cfg_wdata[NIRQ-1:0] : mask_q;

        unique case (state_q)
            IDLE: begin
                if (elig_valid) begin
                    state_d   = REQ;
                    intr_id_d = elig_id;
                end
            end
            REQ: begin
                // Acknowledge beats a same-cycle mask clear of the requested line.
                if (inta) begin
                    state_d             = SERV;
                    pend_clr[intr_id_q] = 1'b1;
                end else if (!mask_d[intr_id_q]) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (eoi_we) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge wins over any clear landing in the same cycle.
        pending_d    = (pending_q & ~pend_clr) | rise;
        intr_d       = (state_d == REQ);
        in_service_d = (state_d == SERV);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (clr) begin
            state_q      <= IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            intr_q       <= 1'b0;
            intr_id_q    <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            intr_q       <= intr_d;
            intr_id_q    <= intr_id_d;
            in_service_q <= in_service_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            ADDR_MASK: cfg_rdata[NIRQ-1:0] = mask_q;
            ADDR_PEND: cfg_rdata[NIRQ-1:0] = pending_q;
            ADDR_EOI:  cfg_rdata = '0;
            ADDR_STAT: begin
                cfg_rdata[STAT_SERV_BIT] = in_service_q;
                cfg_rdata[STAT_INTR_BIT] = intr_q;
                cfg_rdata[IDW-1:0]       = intr_id_q;
            end
            default: cfg_rdata = '0;
        endcase
    end

    assign intr       = intr_q;
    assign intr_id    = intr_id_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_pipe_intr_controller.sv
// Directed scenarios plus randomized traffic checked against a behavioural
// model of the interrupt controller kept inside this bench.
module tb_pipe_intr_controller;

    localparam int NIRQ = 8;
    localparam int IDW  = 3;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic [NIRQ-1:0] irq = '0;
    logic            inta = 1'b0;
    logic            intr;
    logic [IDW-1:0]  intr_id;
    logic            in_service;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_addr = 2'd0;
    logic [31:0]     cfg_wdata = '0;
    logic [31:0]     cfg_rdata;

    int checks = 0;
    int errors = 0;

    // Model: m_req / m_svc hold the id being requested / serviced, or -1.
    logic [NIRQ-1:0] m_pend, m_mask, m_prev;
    int              m_req, m_svc, m_last;

    pipe_intr_controller #(.NIRQ(NIRQ), .IDW(IDW)) dut (
        .clk        (clk),
        .clr        (clr),
        .irq        (irq),
        .inta       (inta),
        .intr       (intr),
        .intr_id    (intr_id),
        .in_service (in_service),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NIRQ-1:0] rise, clr_bits, new_mask, elig;
        if (clr) begin
            m_pend = '0; m_mask = '1; m_prev = '0;
            m_req = -1; m_svc = -1; m_last = 0;
            return;
        end
        rise     = irq & ~m_prev;
        clr_bits = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NIRQ-1:0] : '0;
        new_mask = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[NIRQ-1:0] : m_mask;
        if (m_req >= 0) begin
            if (inta) begin
                clr_bits[m_req] = 1'b1;
                m_svc = m_req;
                m_req = -1;
            end else if (!new_mask[m_req]) begin
                m_req = -1;
            end
        end else if (m_svc >= 0) begin
            if (cfg_we && cfg_addr == 2'd2) m_svc = -1;
        end else begin
            elig = m_pend & m_mask;
            for (int i = 0; i < NIRQ; i++) begin
                if (elig[i]) begin
                    m_req  = i;
                    m_last = i;
                    break;
                end
            end
        end
        m_pend = (m_pend & ~clr_bits) | rise;
        m_mask = new_mask;
        m_prev = irq;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[NIRQ-1:0] = m_mask;
            2'd1: r[NIRQ-1:0] = m_pend;
            2'd3: begin
                r[8]       = (m_svc >= 0);
                r[7]       = (m_req >= 0);
                r[IDW-1:0] = IDW'(m_last);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock: model follows the sampled inputs, strobes drop afterwards.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        inta   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        check(tag, cfg_rdata, exp);
    endtask

    task automatic ack_and_eoi();
        inta = 1'b1;
        tick();
        cfg_write(2'd2, 32'h0);
    endtask

    initial begin
        // Reset
        clr = 1'b1;
        tick(); tick();
        clr = 1'b0;
        check("rst_intr", intr, 0);
        check("rst_id", intr_id, 0);
        check("rst_serv", in_service, 0);
        read_check("rst_mask", 2'd0, 32'hFF);
        read_check("rst_pend", 2'd1, 32'h0);
        read_check("rst_stat", 2'd3, 32'h0);

        // 1: single edge on irq[3]
        irq = 8'h08; tick();
        irq = 8'h00;
        check("t1_intr_n1", intr, 0);
        read_check("t1_pend_n1", 2'd1, 32'h08);
        tick();
        check("t1_intr_n2", intr, 1);
        check("t1_id", intr_id, 3);
        read_check("t1_stat_req", 2'd3, 32'h83);
        inta = 1'b1; tick();
        check("t1_intr_ack", intr, 0);
        check("t1_serv_ack", in_service, 1);
        read_check("t1_pend_ack", 2'd1, 32'h0);
        read_check("t1_stat_serv", 2'd3, 32'h103);
        read_check("t1_eoi_read", 2'd2, 32'h0);
        cfg_write(2'd2, 32'h0);
        check("t1_serv_eoi", in_service, 0);
        check("t1_intr_eoi", intr, 0);

        // 2: simultaneous edges on 5 and 2
        irq = 8'h24; tick(); irq = 8'h00; tick();
        check("t2_intr", intr, 1);
        check("t2_id_first", intr_id, 2);
        inta = 1'b1; tick();
        cfg_write(2'd2, 32'h0);
        check("t2_intr_k1", intr, 0);
        tick();
        check("t2_intr_k2", intr, 1);
        check("t2_id_second", intr_id, 5);
        ack_and_eoi();

        // 3: edge on 1 while servicing 4
        irq = 8'h10; tick(); tick();
        check("t3_id4", intr_id, 4);
        inta = 1'b1; tick();
        irq = 8'h12; tick(); tick(); tick();
        check("t3_intr_serv", intr, 0);
        read_check("t3_pend", 2'd1, 32'h02);
        cfg_write(2'd2, 32'h0);
        check("t3_intr_k1", intr, 0);
        tick();
        check("t3_intr_k2", intr, 1);
        check("t3_id1", intr_id, 1);
        ack_and_eoi();
        irq = 8'h00; tick();

        // 4: masked line 0
        cfg_write(2'd0, 32'hFE);
        irq = 8'h01; tick(); tick(); tick();
        check("t4_intr_masked", intr, 0);
        read_check("t4_pend", 2'd1, 32'h01);
        cfg_write(2'd0, 32'hFF);
        check("t4_intr_w1", intr, 0);
        tick();
        check("t4_intr_unmask", intr, 1);
        check("t4_id0", intr_id, 0);
        ack_and_eoi();
        irq = 8'h00; tick();

        // 5: withdraw by mask, then mask clear racing inta
        irq = 8'h40; tick(); tick();
        check("t5_id6", intr_id, 6);
        cfg_write(2'd0, 32'hBF);
        check("t5_withdraw", intr, 0);
        read_check("t5_pend_kept", 2'd1, 32'h40);
        cfg_write(2'd0, 32'hFF);
        tick();
        check("t5_reissue", intr, 1);
        inta = 1'b1;
        cfg_write(2'd0, 32'hBF);
        check("t5_race_serv", in_service, 1);
        check("t5_race_intr", intr, 0);
        read_check("t5_race_pend", 2'd1, 32'h0);
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd2, 32'h0);
        irq = 8'h00; tick();

        // 6: clr in SERV with irq[2] held
        irq = 8'h04; tick(); tick();
        inta = 1'b1; tick();
        check("t6_serv", in_service, 1);
        clr = 1'b1; tick();
        check("t6_clr_intr", intr, 0);
        check("t6_clr_id", intr_id, 0);
        check("t6_clr_serv", in_service, 0);
        read_check("t6_clr_pend", 2'd1, 32'h0);
        clr = 1'b0; tick();
        check("t6_rel_n1", intr, 0);
        tick();
        check("t6_rel_intr", intr, 1);
        check("t6_rel_id", intr_id, 2);
        ack_and_eoi();
        tick(); tick();
        check("t6_single_edge", intr, 0);
        irq = 8'h00; tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            irq       = irq ^ NIRQ'($urandom & $urandom & $urandom);
            inta      = ($urandom_range(0, 3) == 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = (cfg_addr == 2'd0) ? ($urandom | $urandom) : $urandom;
            clr       = ($urandom_range(0, 149) == 0);
            #1;
            check("rnd_rdata", cfg_rdata, model_rdata(cfg_addr));
            tick();
            clr = 1'b0;
            check("rnd_intr", intr, 32'(m_req >= 0));
            check("rnd_serv", in_service, 32'(m_svc >= 0));
            check("rnd_id", intr_id, 32'(m_last));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
